// File: rtl/msb_first_serial_transmitter.sv
// msb_first_serial_transmitter
//   Serialises a parallel unsigned word MSB-first. Each bit is held on the stream
//   outputs until the consumer accepts it. An optional reference tracker keeps the
//   mod-3 residue of the bits accepted so far, which can serve as a golden model
//   for a downstream multiple-of-three detector.
//
//   Build option: define MOD3_REF_EN to include the residue tracker. When it is
//   undefined, residue is tied to 2'b00 and div3 is tied to 1'b0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   load_valid load request; load_ready: a load can be accepted
//   load_data  word to send, of which the low load_len bits are significant
//   load_len   bit count; 0 drops the load, and values above WIDTH clamp to WIDTH
//   out_ready  consumer accepts out_bit this cycle
//   out_valid  out_bit is valid; out_bit: current serial bit, MSB first
//   out_first  first bit of the word; out_last: last bit of the word
//   busy       word in flight
//   residue    mod-3 value of the accepted bits; div3: residue == 0
module msb_first_serial_transmitter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic [1:0]       residue,
  output logic             div3
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_ready_q, load_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] shamt;
  logic             load_fire;
  logic             xfer_fire;
  logic             load_start;

  assign len_eff    = (load_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : load_len;
  assign shamt      = CNT_W'(WIDTH) - len_eff;
  assign load_fire  = load_valid && load_ready_q;
  assign xfer_fire  = out_valid_q && out_ready;
  // A zero-length load is accepted but does not leave IDLE.
  assign load_start = (state_q == StIdle) && load_fire && (len_eff != '0);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_first_d = out_first_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          shreg_d     = load_data << shamt;  // left-align so the MSB sits at the top
          cnt_d       = len_eff;
          out_first_d = 1'b1;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (xfer_fire) begin
          shreg_d     = shreg_q << 1;
          cnt_d       = cnt_q - CNT_W'(1);
          out_first_d = 1'b0;
          if (cnt_q == CNT_W'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Stream outputs are registered copies of the next state, so they hold during a stall.
    load_ready_d = (state_d == StIdle);
    out_valid_d  = (state_d == StShift);
    busy_d       = (state_d == StShift);
    out_bit_d    = (state_d == StShift) ? shreg_d[WIDTH-1] : 1'b0;
    out_last_d   = (state_d == StShift) && (cnt_d == CNT_W'(1));
    if (state_d != StShift) begin
      out_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      load_ready_q <= load_ready_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
    end
  end

  assign load_ready = load_ready_q;
  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;

`ifdef MOD3_REF_EN
  logic [1:0] residue_q, residue_d;

  // The residue tracks the value of the accepted prefix: r' = (2r + b) mod 3.
  always_comb begin
    residue_d = residue_q;
    if (load_start) begin
      residue_d = 2'd0;
    end else if ((state_q == StShift) && xfer_fire) begin
      case ({residue_q, out_bit_q})
        3'b00_0: residue_d = 2'd0;
        3'b00_1: residue_d = 2'd1;
        3'b01_0: residue_d = 2'd2;
        3'b01_1: residue_d = 2'd0;
        3'b10_0: residue_d = 2'd1;
        3'b10_1: residue_d = 2'd2;
        default: residue_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      residue_q <= 2'd0;
    end else begin
      residue_q <= residue_d;
    end
  end

  assign residue = residue_q;
  assign div3    = (residue_q == 2'd0);
`else
  assign residue = 2'b00;
  assign div3    = 1'b0;
`endif

endmodule

// File: tb/tb_msb_first_serial_transmitter.sv
module tb_msb_first_serial_transmitter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_len;
  logic             out_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic [1:0]       residue;
  logic             div3;

  msb_first_serial_transmitter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_len  (load_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy),
    .residue   (residue),
    .div3      (div3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       b;
    logic       f;
    logic       l;
    logic [1:0] r;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   valid_cycles = 0;
  bit   rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Residue expectations depend on whether the reference tracker is built in.
  function automatic logic [1:0] exp_res(input logic [63:0] v);
`ifdef MOD3_REF_EN
    return 2'(v % 3);
`else
    return 2'd0 + 2'(v & 64'd0);
`endif
  endfunction

  function automatic logic exp_div3(input logic [63:0] v);
`ifdef MOD3_REF_EN
    return (v % 3) == 0;
`else
    return 1'b0 & v[0];
`endif
  endfunction

  // The model works from the numeric value of the word: bit k is presented while the
  // accepted prefix (the top k bits) has been folded into the residue.
  task automatic push_word(input logic [WIDTH-1:0] data, input int len);
    int          l;
    logic [63:0] d;
    logic [63:0] prefix;
    exp_t        e;
    l = (len > WIDTH) ? WIDTH : len;
    d = 64'(data) & ((64'd1 << l) - 64'd1);
    for (int k = 0; k < l; k++) begin
      prefix = d >> (l - k);
      e.b = d[l-1-k];
      e.f = (k == 0);
      e.l = (k == l - 1);
      e.r = exp_res(prefix);
      e.d = exp_div3(prefix);
      exp_q.push_back(e);
    end
  endtask

  // Issue one load; it fires at the first edge where load_ready is seen high.
  task automatic send_word(input logic [WIDTH-1:0] data, input int len, input bit hold);
    bit fired = 0;
    load_data  = data;
    load_len   = CNT_W'(len);
    load_valid = 1'b1;
    for (int i = 0; i < 600 && !fired; i++) begin
      @(negedge clk);
      if (load_ready) begin
        push_word(data, len);
        fired = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!fired) check("load_accept_timeout", 64'd0, 64'd1);
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_q.size() != 0 || busy) && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented bit, pops only when the consumer accepts it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check("out_bit", 64'(out_bit), 64'(e.b));
          check("out_first", 64'(out_first), 64'(e.f));
          check("out_last", 64'(out_last), 64'(e.l));
          check("residue", 64'(residue), 64'(e.r));
          check("div3", 64'(div3), 64'(e.d));
          check("busy", 64'(busy), 64'd1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          vc;
    logic [31:0] rd;
    int          rl;
    logic        pat[8];

    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'd597;
    load_len   = 6'd10;
    out_ready  = 1'b1;

    // Reset with load_valid asserted
    #4;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_residue", 64'(residue), 64'd0);
    check("rst_div3", 64'(div3), 64'(exp_div3(64'd0)));
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_load_ready", 64'(load_ready), 64'd0);
    check("rst_hold_out_valid", 64'(out_valid), 64'd0);
    reset      = 1'b1;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    check("release_load_ready", 64'(load_ready), 64'd1);

    // Basic word 597 / 10
    vc = valid_cycles;
    send_word(32'd597, 10, 0);
    drain();
    check("basic_cycles", 64'(valid_cycles - vc), 64'd10);
    check("basic_final_residue", 64'(residue), 64'(exp_res(64'd597)));
    check("basic_final_div3", 64'(div3), 64'(exp_div3(64'd597)));

    // Backpressure: stall three cycles while bit 4 is presented
    vc = valid_cycles;
    send_word(32'd597, 10, 0);
    base = acc_cnt;
    for (int i = 0; i < 40; i++) begin
      if (acc_cnt - base == 3) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    drain();
    check("bp_cycles", 64'(valid_cycles - vc), 64'd13);
    check("bp_final_residue", 64'(residue), 64'(exp_res(64'd597)));

    // load_len = 0 is accepted and dropped
    vc = valid_cycles;
    send_word(32'hFFFF_FFFF, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("len0_no_valid", 64'(valid_cycles - vc), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_load_ready", 64'(load_ready), 64'd1);

    // load_len = 40 is clamped to 32 bits
    vc = valid_cycles;
    rd = $urandom;
    send_word(rd, 40, 0);
    drain();
    check("len40_cycles", 64'(valid_cycles - vc), 64'd32);
    check("len40_residue", 64'(residue), 64'(exp_res(64'(rd))));

    // Single-bit word
    send_word(32'd1, 1, 0);
    drain();
    check("len1_residue", 64'(residue), 64'(exp_res(64'd1)));

    // Back-to-back: 110, one idle cycle, 111
    send_word(32'd6, 3, 1);
    fork
      send_word(32'd7, 3, 0);
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          pat[i] = out_valid;
          if (i == 3) begin
            check("b2b_idle_residue", 64'(residue), 64'(exp_res(64'd6)));
            check("b2b_idle_div3", 64'(div3), 64'(exp_div3(64'd6)));
          end
        end
      end
    join
    check("b2b_pattern",
          64'({pat[0], pat[1], pat[2], pat[3], pat[4], pat[5], pat[6], pat[7]}),
          64'(8'b1110_1110));
    drain();
    check("b2b_final_residue", 64'(residue), 64'(exp_res(64'd7)));

    // Randomised words and consumer backpressure
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      rd = $urandom;
      rl = $urandom_range(0, 40);
      send_word(rd, rl, ($urandom_range(0, 1) == 1) && (n != 39));
    end
    load_valid = 1'b0;
    drain();
    rand_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Mid-word reset after bit 5
    vc = valid_cycles;
    send_word(32'd597, 10, 0);
    base = acc_cnt;
    for (int i = 0; i < 40 && (acc_cnt - base) < 5; i++) begin
      @(posedge clk);
      #1;
    end
    #1;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_bit", 64'(out_bit), 64'd0);
    check("midrst_residue", 64'(residue), 64'd0);
    exp_q.delete();
    vc = valid_cycles;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_output", 64'(valid_cycles - vc), 64'd0);
    check("midrst_load_ready", 64'(load_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
